srg_sched: RTL and testbench

Two-requester scheduler and sequencer for the 8-bit parallel-load shift register (`x`, `sh_ld`, `clk`, `y`; `sh_ld=0` loads, `sh_ld=1` shifts, `y` is the MSB). It arbitrates byte requests from two sources, drives one load cycle followed by exactly W shift cycles, and flags the cycles in which the register's `y` carries a valid data bit. It sits directly in front of the shift register and is the only block driving its `x` and `sh_ld`.

---
 rtl/srg_sched.sv | 187 ++++++++++++++++++
 tb/tb_srg_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srg_sched.sv
`default_nettype none
// ============================================================================
// Module   : srg_sched
// Desc     : Two-requester arbiter and load/shift sequencer for a PISO shift
//            register. Define SRG_SCHED_FIXPRIO_EN for fixed priority (req0).
// Revision : 1.0  initial release
// ============================================================================
module srg_sched #(
  parameter  int W   = 8,
  parameter  int GAP = 1,
  localparam int B   = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] x,
  output logic         sh_ld,
  output logic         frame_vld,
  output logic [B-1:0] bit_idx,
  output logic         src,
  output logic         busy
);

  localparam logic [B-1:0] IDX_TOP  = B'(W - 1);
  localparam logic [3:0]   GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic           sh_ld_q, sh_ld_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           frame_vld_q, frame_vld_d;
  logic [B-1:0]   bit_idx_q, bit_idx_d;
  logic           src_q, src_d;
  logic           busy_q, busy_d;
  logic [3:0]     gap_cnt_q, gap_cnt_d;

  logic           win_vld;
  logic           win_src;
  logic           arb;
  logic           grant;

  assign win_vld = req0 | req1;

`ifdef SRG_SCHED_FIXPRIO_EN
  // req0 takes every tie; req1 only wins when req0 is low
  always_comb begin
    win_src = ~req0;
  end
`else
  // last_q holds the most recent winner; reset value 1 favours req0
  logic last_q, last_d;

  always_comb begin
    win_src = (req0 && req1) ? ~last_q : ~req0;
    last_d  = last_q;
    if (grant) begin
      last_d = win_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    sh_ld_d     = 1'b1;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    frame_vld_d = frame_vld_q;
    bit_idx_d   = bit_idx_q;
    src_d       = src_q;
    busy_d      = busy_q;
    gap_cnt_d   = gap_cnt_q;
    arb         = 1'b0;
    grant       = 1'b0;

    case (state_q)
      S_IDLE: begin
        arb = 1'b1;
      end
      S_LOAD: begin
        state_d     = S_SHIFT;
        frame_vld_d = 1'b1;
        bit_idx_d   = IDX_TOP;
        busy_d      = 1'b1;
      end
      S_SHIFT: begin
        if (bit_idx_q == '0) begin
          frame_vld_d = 1'b0;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_INIT;
          end else begin
            arb = 1'b1;
          end
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          arb = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The arbitration point either starts a new frame or parks in IDLE
    if (arb) begin
      frame_vld_d = 1'b0;
      if (win_vld) begin
        grant   = 1'b1;
        state_d = S_LOAD;
        x_d     = win_src ? d1 : d0;
        sh_ld_d = 1'b0;
        ack0_d  = ~win_src;
        ack1_d  = win_src;
        src_d   = win_src;
        busy_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      sh_ld_q     <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      frame_vld_q <= 1'b0;
      bit_idx_q   <= '0;
      src_q       <= 1'b0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      sh_ld_q     <= sh_ld_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      frame_vld_q <= frame_vld_d;
      bit_idx_q   <= bit_idx_d;
      src_q       <= src_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign x         = x_q;
  assign sh_ld     = sh_ld_q;
  assign frame_vld = frame_vld_q;
  assign bit_idx   = bit_idx_q;
  assign src       = src_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_srg_sched.sv
`default_nettype none
// Bench for srg_sched: table of grant records checked through an expected-frame
// queue, plus hand-written back-to-back (GAP=0) and mid-frame reset sequences.
module tb_srg_sched;
  localparam int W = 8;
  localparam int B = 3;
`ifdef SRG_SCHED_FIXPRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;

  logic         ack0, ack1, sh_ld, frame_vld, src, busy;
  logic [W-1:0] x;
  logic [B-1:0] bit_idx;
  logic         ack0_b, ack1_b, sh_ld_b, fv_b, src_b, busy_b;
  logic [W-1:0] x_b;
  logic [B-1:0] bit_idx_b;

  always #5 clk = ~clk;

  srg_sched #(.W(W), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .ack0(ack0), .ack1(ack1), .x(x), .sh_ld(sh_ld), .frame_vld(frame_vld),
    .bit_idx(bit_idx), .src(src), .busy(busy)
  );

  srg_sched #(.W(W), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .ack0(ack0_b), .ack1(ack1_b), .x(x_b), .sh_ld(sh_ld_b), .frame_vld(fv_b),
    .bit_idx(bit_idx_b), .src(src_b), .busy(busy_b)
  );

  // Behavioural model of the external shift registers fed by each scheduler
  logic [W-1:0] sr = '0, sr_b = '0;
  logic         y, y_b;
  always @(posedge clk) begin
    sr   <= sh_ld   ? {sr[W-2:0], 1'b0}   : x;
    sr_b <= sh_ld_b ? {sr_b[W-2:0], 1'b0} : x_b;
  end
  assign y   = sr[W-1];
  assign y_b = sr_b[W-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic         src;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  exp_t mon_e;
  logic [W-1:0] mon_cur = '0;
  int   mon_k = 0;
  logic fv_prev = 1'b0;

  // Scoreboard monitor for the GAP=1 instance
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack0 | ack1) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 32'(ack1), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_onehot", 32'(ack0 ^ ack1), 1);
          chk("ack_src", 32'(ack1), 32'(mon_e.src));
          chk("load_sh_ld", 32'(sh_ld), 0);
          chk("load_x", 32'(x), 32'(mon_e.data));
          chk("load_src", 32'(src), 32'(mon_e.src));
          chk("load_busy", 32'(busy), 1);
          mon_cur = mon_e.data;
        end
        mon_k = 0;
      end
      if (frame_vld) begin
        chk("shift_bit_idx", 32'(bit_idx), 32'(W - 1 - mon_k));
        chk("shift_sh_ld", 32'(sh_ld), 1);
        if (mon_k < W) chk("shift_y", 32'(y), 32'(mon_cur[W-1-mon_k]));
        mon_k++;
      end
      if (!frame_vld && fv_prev) chk("frame_len", 32'(mon_k), W);
      fv_prev = frame_vld;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sh_ld", 32'(sh_ld), 1);
    chk("rst_x", 32'(x), 0);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_frame_vld", 32'(frame_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bit_idx", 32'(bit_idx), 0);
    chk("rst_src", 32'(src), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    rst = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy && !frame_vld && !busy_b) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_grant(output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  typedef struct {
    bit           rst_before;
    logic         req0;
    logic         req1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         exp_src;
    logic [W-1:0] exp_x;
    int           period;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   at, last;
    bit   ok;
    logic [W-1:0] pat;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b0, 8'hAA, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'hAA, 8'h55, FIX ? 1'b0 : 1'b1, FIX ? 8'hAA : 8'h55, 10};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b0, 8'hAA, 10};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'hAA, 8'h55, FIX ? 1'b0 : 1'b1, FIX ? 8'hAA : 8'h55, 10};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'hAA, 8'h55, 1'b1, 8'h55, 10};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h3C, 8'h55, 1'b0, 8'h3C, 10};

    mon_en = 1'b1;
    last   = 0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst_before) begin
        req0 = 1'b0;
        req1 = 1'b0;
        drain();
        req0 = tbl[i].req0; req1 = tbl[i].req1; d0 = tbl[i].d0; d1 = tbl[i].d1;
        do_reset();
      end else begin
        req0 = tbl[i].req0; req1 = tbl[i].req1; d0 = tbl[i].d0; d1 = tbl[i].d1;
      end
      e.src  = tbl[i].exp_src;
      e.data = tbl[i].exp_x;
      exp_q.push_back(e);
      wait_grant(at, ok);
      if (ok && tbl[i].period != 0) chk("grant_period", 32'(at - last), 32'(tbl[i].period));
      last = at;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    drain();
    chk("queue_empty", 32'(exp_q.size()), 0);
    mon_en = 1'b0;

    // Back-to-back on the GAP=0 instance: LOAD then 8 valid bits, period 9
    pat  = 8'hF0;
    req1 = 1'b1;
    d1   = pat;
    do_reset();
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      chk("b2b_ack1", 32'(ack1_b), 32'((c % 9) == 0));
      chk("b2b_frame_vld", 32'(fv_b), 32'((c % 9) != 0));
      if ((c % 9) != 0) chk("b2b_y", 32'(y_b), 32'(pat[8 - (c % 9)]));
    end

    // Mid-frame reset at bit_idx=3 with req1 still held
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (frame_vld && bit_idx == 3'd3) ok = 1'b1;
    end
    chk("midrst_reach_idx3", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sh_ld", 32'(sh_ld), 1);
    chk("midrst_x", 32'(x), 0);
    chk("midrst_ack1", 32'(ack1), 0);
    chk("midrst_frame_vld", 32'(frame_vld), 0);
    chk("midrst_bit_idx", 32'(bit_idx), 0);
    chk("midrst_src", 32'(src), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("regrant_ack1", 32'(ack1), 1);
    chk("regrant_sh_ld", 32'(sh_ld), 0);
    chk("regrant_x", 32'(x), 32'h0F0);
    chk("regrant_src", 32'(src), 1);
    req1 = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
